// File: rtl/detector_jogada.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, one jogada pulse per accepted press.
// Optional macro DETECTOR_JOGADA_NA_SOLTURA_EN moves the pulse to release completion.
module detector_jogada #(
    parameter int N_BOTOES = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                jogada,
    output logic [N_BOTOES-1:0] botoes_reg,
    output logic                multiplo,
    output logic [2:0]          db_estado
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [N_BOTOES-1:0] NENHUM = N_BOTOES'(0);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        FILTRA      = 3'd1,
        ACEITA      = 3'd2,
        PRESSIONADO = 3'd3,
        SOLTA       = 3'd4
    } estado_t;

    function automatic logic mais_de_um(input logic [N_BOTOES-1:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < N_BOTOES; i++) begin
            n = n + 32'(v[i]);
        end
        return (n > 32'd1);
    endfunction

    estado_t               estado_q, estado_d;
    logic [N_BOTOES-1:0]   sync1_q, sync2_q;
    logic [N_BOTOES-1:0]   amostra_q, amostra_d;
    logic [CW-1:0]         cont_q, cont_d;
    logic                  jogada_q, jogada_d;
    logic [N_BOTOES-1:0]   botoes_reg_q, botoes_reg_d;
    logic                  multiplo_q, multiplo_d;

    // Next-state and next-output logic; only the synchronized code drives decisions.
    always_comb begin
        estado_d     = estado_q;
        amostra_d    = amostra_q;
        cont_d       = cont_q;
        jogada_d     = 1'b0;
        botoes_reg_d = botoes_reg_q;
        multiplo_d   = multiplo_q;
        case (estado_q)
            OCIOSO: begin
                if ((sync2_q != NENHUM) && habilita) begin
                    estado_d  = FILTRA;
                    amostra_d = sync2_q;
                    cont_d    = CNT_ZERO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            FILTRA: begin
                if (!habilita) begin
                    estado_d = OCIOSO;
                end else if (sync2_q != amostra_q) begin
                    estado_d = OCIOSO;
                    cont_d   = CNT_ZERO;
                end else if (cont_q == CNT_MAX) begin
                    botoes_reg_d = amostra_q;
                    multiplo_d   = mais_de_um(amostra_q);
                    cont_d       = CNT_ZERO;
`ifdef DETECTOR_JOGADA_NA_SOLTURA_EN
                    estado_d     = PRESSIONADO;
`else
                    estado_d     = ACEITA;
                    jogada_d     = 1'b1;
`endif
                end else begin
                    cont_d = cont_q + CNT_ONE;
                end
            end
            ACEITA: begin
                cont_d = CNT_ZERO;
`ifdef DETECTOR_JOGADA_NA_SOLTURA_EN
                estado_d = OCIOSO;
`else
                estado_d = PRESSIONADO;
`endif
            end
            PRESSIONADO: begin
                if (sync2_q == NENHUM) begin
                    estado_d = SOLTA;
                    cont_d   = CNT_ZERO;
                end else begin
                    estado_d = PRESSIONADO;
                end
            end
            SOLTA: begin
                // Any nonzero code during release is bounce, never a new press.
                if (sync2_q != NENHUM) begin
                    estado_d = PRESSIONADO;
                    cont_d   = CNT_ZERO;
                end else if (cont_q == CNT_MAX) begin
                    cont_d = CNT_ZERO;
`ifdef DETECTOR_JOGADA_NA_SOLTURA_EN
                    estado_d = ACEITA;
                    jogada_d = 1'b1;
`else
                    estado_d = OCIOSO;
`endif
                end else begin
                    cont_d = cont_q + CNT_ONE;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = CNT_ZERO;
            end
        endcase
    end

    // State, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= NENHUM;
            sync2_q      <= NENHUM;
            estado_q     <= OCIOSO;
            amostra_q    <= NENHUM;
            cont_q       <= CNT_ZERO;
            jogada_q     <= 1'b0;
            botoes_reg_q <= NENHUM;
            multiplo_q   <= 1'b0;
        end else begin
            sync1_q      <= botoes;
            sync2_q      <= sync1_q;
            estado_q     <= estado_d;
            amostra_q    <= amostra_d;
            cont_q       <= cont_d;
            jogada_q     <= jogada_d;
            botoes_reg_q <= botoes_reg_d;
            multiplo_q   <= multiplo_d;
        end
    end

    assign jogada     = jogada_q;
    assign botoes_reg = botoes_reg_q;
    assign multiplo   = multiplo_q;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: expected pulses are queued at stimulus time and
// matched by a monitor against pulse edge, code and multiplo.
module tb_detector_jogada;

    localparam int DB = 4;
`ifdef DETECTOR_JOGADA_NA_SOLTURA_EN
    localparam bit SOLTURA = 1'b1;
`else
    localparam bit SOLTURA = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       jogada;
    logic [3:0] botoes_reg;
    logic       multiplo;
    logic [2:0] db_estado;

    typedef struct {
        int         ed;
        logic [3:0] code;
        logic       mult;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic jog_prev = 1'b0;

    detector_jogada #(.N_BOTOES(4), .DEBOUNCE(DB)) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita),
        .jogada(jogada), .botoes_reg(botoes_reg), .multiplo(multiplo), .db_estado(db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic push_exp(input int ed, input logic [3:0] code);
        exp_t e;
        e.ed   = ed;
        e.code = code;
        e.mult = ($countones(code) > 1);
        q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (edge_cnt < n) @(negedge clock);
    endtask

    task automatic check_db(input string name, input logic [2:0] exp_db);
        n_checks++;
        if (db_estado !== exp_db) begin
            n_fail++;
            $display("FAIL %s: edge %0d db_estado=%0d expected %0d", name, edge_cnt, db_estado, exp_db);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            edge_cnt++;
            if (jogada === 1'b1) begin
                n_checks++;
                if (jog_prev) begin
                    n_fail++;
                    $display("FAIL jogada_consecutive: high again at edge %0d", edge_cnt);
                end
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: jogada at edge %0d code=%b, none expected", edge_cnt, botoes_reg);
                end else begin
                    e = q.pop_front();
                    n_checks++;
                    if (e.ed != edge_cnt) begin
                        n_fail++;
                        $display("FAIL pulse_edge: got edge %0d expected %0d", edge_cnt, e.ed);
                    end
                    n_checks++;
                    if (botoes_reg !== e.code || multiplo !== e.mult) begin
                        n_fail++;
                        $display("FAIL pulse_code: got %b/%b expected %b/%b", botoes_reg, multiplo, e.code, e.mult);
                    end
                end
            end
            jog_prev = (jogada === 1'b1);
        end
    endtask

    task automatic press_and_accept(input logic [3:0] code);
        int e;
        botoes = code;
        e = edge_cnt;
        if (!SOLTURA) push_exp(e + DB + 3, code);
        wait_until(e + DB + 6);
        check_db("press_held_state", 3'd3);
        n_checks++;
        if (botoes_reg !== code) begin
            n_fail++;
            $display("FAIL press_code: botoes_reg=%b expected %b", botoes_reg, code);
        end
    endtask

    task automatic release_and_settle(input logic [3:0] code);
        int r;
        botoes = 4'b0000;
        r = edge_cnt;
        if (SOLTURA) push_exp(r + DB + 3, code);
        wait_until(r + DB + 5);
        check_db("release_idle", 3'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_checks++;
            if ({jogada, botoes_reg, multiplo, db_estado} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_idle: jogada=%b reg=%b mult=%b db=%0d expected all 0",
                         jogada, botoes_reg, multiplo, db_estado);
            end
        end
    endtask

    task automatic test_single_press();
        int e;
        int r;
        botoes = 4'b0100;
        e = edge_cnt;
        if (!SOLTURA) push_exp(e + DB + 3, 4'b0100);
        wait_until(e + DB + 2);
        check_db("single_filtra_last", 3'd1);
        wait_until(e + DB + 3);
        check_db("single_accept_state", SOLTURA ? 3'd3 : 3'd2);
        n_checks++;
        if (botoes_reg !== 4'b0100 || multiplo !== 1'b0) begin
            n_fail++;
            $display("FAIL single_code: got %b/%b expected 0100/0", botoes_reg, multiplo);
        end
        wait_until(e + 30);
        check_db("single_hold", 3'd3);
        botoes = 4'b0000;
        r = edge_cnt;
        if (SOLTURA) push_exp(r + DB + 3, 4'b0100);
        wait_until(r + DB + 2);
        check_db("single_solta_last", 3'd4);
        wait_until(r + DB + 3);
        check_db("single_release_done", SOLTURA ? 3'd2 : 3'd0);
        wait_until(r + DB + 6);
        check_db("single_idle", 3'd0);
    endtask

    task automatic test_bounce();
        int s;
        for (int i = 0; i < 3; i++) begin
            botoes = 4'b0010;
            repeat (2) @(negedge clock);
            botoes = 4'b0000;
            repeat (2) @(negedge clock);
        end
        botoes = 4'b0010;
        s = edge_cnt;
        if (!SOLTURA) push_exp(s + DB + 3, 4'b0010);
        wait_until(s + DB + 2);
        check_db("bounce_filtra", 3'd1);
        wait_until(s + DB + 6);
        n_checks++;
        if (botoes_reg !== 4'b0010) begin
            n_fail++;
            $display("FAIL bounce_code: botoes_reg=%b expected 0010", botoes_reg);
        end
        release_and_settle(4'b0010);
    endtask

    task automatic test_habilita();
        int h;
        habilita = 1'b0;
        botoes   = 4'b0001;
        repeat (10) @(negedge clock);
        check_db("habilita_blocked", 3'd0);
        habilita = 1'b1;
        h = edge_cnt;
        if (!SOLTURA) push_exp(h + DB + 1, 4'b0001);
        wait_until(h + DB);
        check_db("habilita_filtra", 3'd1);
        wait_until(h + DB + 1);
        check_db("habilita_accept", SOLTURA ? 3'd3 : 3'd2);
        habilita = 1'b0;
        release_and_settle(4'b0001);
        habilita = 1'b1;
        press_and_accept(4'b1001);
        n_checks++;
        if (multiplo !== 1'b1) begin
            n_fail++;
            $display("FAIL multiplo: got %b expected 1", multiplo);
        end
        release_and_settle(4'b1001);
    endtask

    task automatic test_release_bounce();
        int r;
        press_and_accept(4'b0100);
        botoes = 4'b0000; repeat (2) @(negedge clock);
        botoes = 4'b0100; repeat (2) @(negedge clock);
        botoes = 4'b0000; repeat (2) @(negedge clock);
        botoes = 4'b0100; @(negedge clock);
        botoes = 4'b0000;
        r = edge_cnt;
        if (SOLTURA) push_exp(r + DB + 3, 4'b0100);
        wait_until(r + DB + 2);
        check_db("relbounce_solta", 3'd4);
        wait_until(r + DB + 3);
        check_db("relbounce_done", SOLTURA ? 3'd2 : 3'd0);
        wait_until(r + DB + 5);
        check_db("relbounce_idle", 3'd0);
    endtask

    task automatic test_reset_filtra();
        int e;
        int d;
        botoes = 4'b0010;
        e = edge_cnt;
        wait_until(e + 4);
        check_db("rstf_in_filtra", 3'd1);
        reset = 1'b1;
        wait_until(e + 5);
        n_checks++;
        if (db_estado !== 3'd0 || jogada !== 1'b0 || botoes_reg !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstf_abort: db=%0d jogada=%b reg=%b expected 0/0/0000", db_estado, jogada, botoes_reg);
        end
        reset = 1'b0;
        d = edge_cnt;
        if (!SOLTURA) push_exp(d + DB + 3, 4'b0010);
        wait_until(d + DB + 6);
        check_db("rstf_new_press", 3'd3);
        release_and_settle(4'b0010);
    endtask

    initial begin
        reset    = 1'b1;
        botoes   = 4'b0000;
        habilita = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        reset = 1'b0;
        test_reset();
        habilita = 1'b1;
        test_single_press();
        test_bounce();
        test_habilita();
        test_release_bounce();
        test_reset_filtra();
        repeat (10) @(negedge clock);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
